xbus_rr: RTL and testbench
==========================

Name: xbus_rr

Overview:
- Parametrised, registered successor to the fixed 4-master/6-slave combinational bus.
- Connects NM masters to NS slaves and decodes the slave from address bits [31:28].
- Arbitrates round-robin, locks the bus for one transaction, and completes every transaction with a req/ack handshake. A slave may stretch its response.
- Sits between the core/debug/uart-loader masters and the rom/ram/peripheral slaves. Drives pipeline hold.

Parameters:
- NM, 4, number of masters (2..8).
- NS, 6, number of slaves (1..16). Region n = addr[31:28] == n.
- TIMEOUT, 255, cycles waiting for slave ack before an error response (1..65535).
- HOLD_MASK, 4'b1101, one bit per master; masters whose requests stall the pipeline via hold_o.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active high
- m_req_i  in  NM  master request; held high until m_ack_o
- m_we_i  in  NM  write enable per master
- m_addr_i  in  NM*32  master address, master k at [k*32+:32]
- m_data_i  in  NM*32  master write data
- m_ack_o  out  NM  one-cycle completion pulse
- m_err_o  out  NM  error qualifier, valid with m_ack_o
- m_data_o  out  NM*32  read data, held per master until that master's next ack
- s_req_o  out  NS  slave select/strobe
- s_we_o  out  NS  slave write enable
- s_addr_o  out  NS*32  slave address {4'd0, addr[27:0]}
- s_data_o  out  NS*32  slave write data
- s_ack_i  in  NS  slave done; may be asserted in the same cycle as s_req_o
- s_data_i  in  NS*32  slave read data, sampled with s_ack_i
- hold_o  out  1  pipeline stall

Behaviour:
- Reset values: all outputs 0; state IDLE; last-grant pointer = NM-1, so master 0 wins first.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If any m_req_i is high, select the winner: first requesting index scanning upward from last+1, wrapping modulo NM.
  - Latch the winner's index, addr, data and we.
  - Decode region r = addr[31:28].
  - If r < NS, go to BUSY. Otherwise go to RESP with err=1 and rdata=0; no slave is touched.
- BUSY:
  - Drive s_req_o[r]=1, s_we_o[r], s_addr_o[r] and s_data_o[r] from the latched values. All other slave outputs are 0.
  - On s_ack_i[r]: capture s_data_i[r] (captured on writes too) and go to RESP with err=0.
  - Wait counter increments each BUSY cycle. On reaching TIMEOUT without ack, go to RESP with err=1 and rdata=0.
  - s_ack_i from a non-selected slave is ignored.
- RESP:
  - m_ack_o[idx]=1 and m_err_o[idx]=err for exactly one cycle.
  - m_data_o[idx] is updated from a register; other masters' m_data_o are unchanged.
  - last = idx. Go to IDLE.
- Latency: request to ack is 3 cycles minimum (zero-wait slave). Back-to-back transactions cost 3 cycles each.
- Master protocol: a master must drop m_req_i on the cycle after it sees m_ack_o. m_req_i still high in IDLE after RESP is treated as a new request.
- Dropped request: if m_req_i falls during BUSY, the transaction still completes and ack is still pulsed.
- Input stability: m_addr_i, m_data_i and m_we_i changes after the IDLE sample are ignored.
- Simultaneous requests: round-robin guarantees each requester is served within NM transactions.
- hold_o (combinational): high when any request bit in m_req_i & HOLD_MASK is high, or when state != IDLE and the latched idx is in HOLD_MASK.
- Reset mid-transaction: abort immediately. No ack is issued, and slave outputs are 0 the next cycle.
- Wait counter: width clog2(TIMEOUT+1); cleared on IDLE->BUSY.

Optional Feature:
- Macro: XBUS_RR_TIMEOUT_EN.
- Defined: timeout behaviour as above.
- Undefined: no counter; BUSY waits indefinitely for s_ack_i; m_err_o is set only for unmapped regions.

Decomposition:
- Package xbus_pkg holds:
  - state encoding localparams (IDLE=2'd0, BUSY=2'd1, RESP=2'd2);
  - REGION_MSB=31, REGION_LSB=28;
  - the address-strip rule.
- One natural sub-module, xbus_rr_arb: NM-wide round-robin arbiter. Inputs are the req vector and last pointer; outputs are a one-hot grant and an index. It is purely combinational and instantiated by xbus_rr.

Test Plan:
- Master 1 read addr 0x1000_0010; slave1 acks in the BUSY cycle with data 0xDEADBEEF -> s_addr_o[1]=0x0000_0010; m_ack_o[1] pulses at cycle 3; m_data_o[1]=0xDEADBEEF; m_err_o=0.
- Masters 0, 2 and 3 all request writes continuously to slave 4 -> grants in order 0,2,3,0,...; each slave write appears once with the correct data; no master is starved.
- Master 3 accesses addr 0x9000_0000 with NS=6 -> no s_req_o asserted; m_ack_o[3] with m_err_o[3]=1 and m_data_o[3]=0 in 2 cycles.
- Slave 2 never acks, TIMEOUT=8, macro defined -> ack+err after 8 BUSY cycles; the next request is served normally. With the macro undefined -> the bus stays in BUSY.
- rst asserted during BUSY -> next cycle all s_req_o=0 and m_ack_o=0; master 0 wins the first post-reset request.
- Master 1 (not in HOLD_MASK) active alone -> hold_o=0. Master 0 request raised -> hold_o=1 the same cycle, staying high until m_req_i[0] drops after ack.

Source files
------------

// File: rtl/xbus_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | xbus_pkg : shared encodings and address helpers for xbus_rr       |
// | Rev 1.0  : initial release                                        |
// +------------------------------------------------------------------+
package xbus_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam int REGION_MSB = 31;
  localparam int REGION_LSB = 28;

  // Slaves see a region-relative address: the region nibble is zeroed.
  function automatic logic [31:0] strip_addr(input logic [31:0] addr);
    return {4'd0, addr[REGION_LSB-1:0]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/xbus_rr_arb.sv
`default_nettype none
// +------------------------------------------------------------------+
// | xbus_rr_arb : combinational round-robin arbiter, scan from last+1 |
// | Rev 1.0     : initial release                                     |
// +------------------------------------------------------------------+
module xbus_rr_arb #(
  parameter int NM = 4,
  parameter int IW = 2
) (
  input  logic [NM-1:0] req,
  input  logic [IW-1:0] last,
  output logic [NM-1:0] grant,
  output logic [IW-1:0] idx
);

  logic          found;
  logic [IW-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int off = 1; off <= NM; off++) begin
      cand = IW'((int'(last) + off) % NM);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/xbus_rr.sv
`default_nettype none
// +------------------------------------------------------------------+
// | xbus_rr : registered NM x NS round-robin bus with req/ack handshake|
// | Option  : XBUS_RR_TIMEOUT_EN enables the slave-ack timeout         |
// | Rev 1.0 : initial release                                          |
// +------------------------------------------------------------------+
module xbus_rr
  import xbus_pkg::*;
#(
  parameter int            NM        = 4,
  parameter int            NS        = 6,
  parameter int            TIMEOUT   = 255,
  parameter logic [NM-1:0] HOLD_MASK = 4'b1101
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NM-1:0]    m_req_i,
  input  logic [NM-1:0]    m_we_i,
  input  logic [NM*32-1:0] m_addr_i,
  input  logic [NM*32-1:0] m_data_i,
  output logic [NM-1:0]    m_ack_o,
  output logic [NM-1:0]    m_err_o,
  output logic [NM*32-1:0] m_data_o,
  output logic [NS-1:0]    s_req_o,
  output logic [NS-1:0]    s_we_o,
  output logic [NS*32-1:0] s_addr_o,
  output logic [NS*32-1:0] s_data_o,
  input  logic [NS-1:0]    s_ack_i,
  input  logic [NS*32-1:0] s_data_i,
  output logic             hold_o
);

  localparam int IW = $clog2(NM);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [IW-1:0]    last;
  logic [IW-1:0]    idx;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic             we_q;
  logic             err_q;
  logic [NM*32-1:0] mdata_q;

  logic [NM-1:0]    grant;
  logic [IW-1:0]    win_idx;
  logic [31:0]      sel_addr;
  logic [31:0]      sel_wdata;
  logic             sel_we;
  logic             sel_mapped;
  logic [3:0]       region;
  logic             slv_ack;
  logic [31:0]      slv_rdata;
  logic             timed_out;

  xbus_rr_arb #(.NM(NM), .IW(IW)) u_arb (
    .req   (m_req_i),
    .last  (last),
    .grant (grant),
    .idx   (win_idx)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    for (int k = 0; k < NM; k++) begin
      if (grant[k]) begin
        sel_addr  = sel_addr  | m_addr_i[k*32 +: 32];
        sel_wdata = sel_wdata | m_data_i[k*32 +: 32];
        sel_we    = sel_we    | m_we_i[k];
      end
    end
  end

  assign sel_mapped = (32'(sel_addr[REGION_MSB:REGION_LSB]) < NS);
  assign region     = addr_q[REGION_MSB:REGION_LSB];

  // Only the latched region's ack/data are looked at; other slaves are ignored.
  always_comb begin
    slv_ack   = 1'b0;
    slv_rdata = '0;
    for (int s = 0; s < NS; s++) begin
      if (region == 4'(s)) begin
        slv_ack   = s_ack_i[s];
        slv_rdata = s_data_i[s*32 +: 32];
      end
    end
  end

`ifdef XBUS_RR_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (rst || state != BUSY) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign timed_out = (state == BUSY) && (wait_cnt == CW'(TIMEOUT - 1));
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|m_req_i) state_nxt = sel_mapped ? BUSY : RESP;
      BUSY:    if (slv_ack || timed_out) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Read data lands in the per-master register on entry to RESP so it is valid with ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      last    <= IW'(NM - 1);
      idx     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      mdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|m_req_i) begin
            idx     <= win_idx;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            we_q    <= sel_we;
            err_q   <= !sel_mapped;
            if (!sel_mapped) mdata_q[int'(win_idx)*32 +: 32] <= '0;
          end
        end
        BUSY: begin
          if (slv_ack) begin
            err_q                        <= 1'b0;
            mdata_q[int'(idx)*32 +: 32] <= slv_rdata;
          end else if (timed_out) begin
            err_q                        <= 1'b1;
            mdata_q[int'(idx)*32 +: 32] <= '0;
          end
        end
        RESP:    last <= idx;
        default: ;
      endcase
    end
  end

  always_comb begin
    s_req_o  = '0;
    s_we_o   = '0;
    s_addr_o = '0;
    s_data_o = '0;
    m_ack_o  = '0;
    m_err_o  = '0;
    if (state == BUSY) begin
      for (int s = 0; s < NS; s++) begin
        if (region == 4'(s)) begin
          s_req_o[s]           = 1'b1;
          s_we_o[s]            = we_q;
          s_addr_o[s*32 +: 32] = strip_addr(addr_q);
          s_data_o[s*32 +: 32] = wdata_q;
        end
      end
    end
    if (state == RESP) begin
      m_ack_o[idx] = 1'b1;
      m_err_o[idx] = err_q;
    end
  end

  assign m_data_o = mdata_q;
  assign hold_o   = (|(m_req_i & HOLD_MASK)) | ((state != IDLE) & HOLD_MASK[idx]);

endmodule
`default_nettype wire

// File: tb/tb_xbus_rr.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_xbus_rr : directed self-checking bench for xbus_rr             |
// | Rev 1.0    : initial release                                      |
// +------------------------------------------------------------------+
module tb_xbus_rr;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   m_req, m_we;
  logic [127:0] m_addr, m_wdata;
  logic [3:0]   m_ack_o, m_err_o;
  logic [127:0] m_data_o;
  logic [5:0]   s_req_o, s_we_o;
  logic [191:0] s_addr_o, s_data_o;
  logic [5:0]   s_ack_i;
  logic [191:0] s_data_i;
  logic         hold_o;

  logic [5:0]   slv_en;
  logic [31:0]  slv_data [6];
  logic [31:0]  wlog_addr [$];
  logic [31:0]  wlog_data [$];

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  xbus_rr #(.NM(4), .NS(6), .TIMEOUT(8), .HOLD_MASK(4'b1101)) dut (
    .clk      (clk),
    .rst      (rst),
    .m_req_i  (m_req),
    .m_we_i   (m_we),
    .m_addr_i (m_addr),
    .m_data_i (m_wdata),
    .m_ack_o  (m_ack_o),
    .m_err_o  (m_err_o),
    .m_data_o (m_data_o),
    .s_req_o  (s_req_o),
    .s_we_o   (s_we_o),
    .s_addr_o (s_addr_o),
    .s_data_o (s_data_o),
    .s_ack_i  (s_ack_i),
    .s_data_i (s_data_i),
    .hold_o   (hold_o)
  );

  // Zero-wait slaves: ack in the same cycle as the strobe when enabled.
  always_comb begin
    s_ack_i = s_req_o & slv_en;
    for (int s = 0; s < 6; s++) s_data_i[s*32 +: 32] = slv_data[s];
  end

  always @(posedge clk) begin
    if (!rst && s_req_o[4] && s_ack_i[4] && s_we_o[4]) begin
      wlog_addr.push_back(s_addr_o[4*32 +: 32]);
      wlog_data.push_back(s_data_o[4*32 +: 32]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_master(input int k, input logic req, input logic we,
                            input logic [31:0] addr, input logic [31:0] data);
    m_req[k]               = req;
    m_we[k]                = we;
    m_addr[k*32 +: 32]     = addr;
    m_wdata[k*32 +: 32]    = data;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++; if (m_ack_o !== 4'b0 || m_err_o !== 4'b0) $display("FAIL reset_ack: ack=%b err=%b expected 0", m_ack_o, m_err_o); else passed++;
    total++; if (m_data_o !== 128'b0) $display("FAIL reset_mdata: got %h expected 0", m_data_o); else passed++;
    total++; if (s_req_o !== 6'b0 || s_addr_o !== 192'b0) $display("FAIL reset_slave: req=%b addr=%h expected 0", s_req_o, s_addr_o); else passed++;
    total++; if (hold_o !== 1'b0) $display("FAIL reset_hold: got %b expected 0", hold_o); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_read();
    slv_data[1] = 32'hDEAD_BEEF;
    set_master(1, 1'b1, 1'b0, 32'h1000_0010, 32'h0);
    tick();
    total++; if (s_req_o !== 6'b000010) $display("FAIL rd_sreq: got %b expected 000010", s_req_o); else passed++;
    total++; if (s_addr_o[63:32] !== 32'h0000_0010) $display("FAIL rd_saddr: got %h expected 00000010", s_addr_o[63:32]); else passed++;
    total++; if (m_ack_o !== 4'b0) $display("FAIL rd_early_ack: got %b expected 0000", m_ack_o); else passed++;
    tick();
    total++; if (m_ack_o !== 4'b0010 || m_err_o !== 4'b0) $display("FAIL rd_ack: ack=%b err=%b expected 0010/0000", m_ack_o, m_err_o); else passed++;
    total++; if (m_data_o[63:32] !== 32'hDEAD_BEEF) $display("FAIL rd_data: got %h expected deadbeef", m_data_o[63:32]); else passed++;
    m_req[1] = 1'b0;
    tick();
    total++; if (m_ack_o !== 4'b0) $display("FAIL rd_pulse: got %b expected 0000", m_ack_o); else passed++;
  endtask

  task automatic test_round_robin();
    int exp_order [6] = '{0, 2, 3, 0, 2, 3};
    int cnt [4] = '{0, 0, 0, 0};
    logic [3:0] drop = 4'b0;
    int n = 0;
    int got;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wlog_addr.delete();
    wlog_data.delete();
    slv_data[4] = 32'h4444_4444;
    for (int k = 0; k < 4; k++)
      if (k != 1) set_master(k, 1'b1, 1'b1, 32'h4000_0100 + 32'(k*4), {16'hC0DE, 8'(k), 8'd0});
    for (int cyc = 0; cyc < 40 && n < 6; cyc++) begin
      tick();
      m_req = m_req | drop;
      drop  = 4'b0;
      if (m_ack_o != 4'b0) begin
        got = 0;
        for (int k = 0; k < 4; k++) if (m_ack_o[k]) got = k;
        total++; if (got != exp_order[n]) $display("FAIL rr_order%0d: got master %0d expected %0d", n, got, exp_order[n]); else passed++;
        total++; if (m_err_o !== 4'b0) $display("FAIL rr_err%0d: got %b expected 0000", n, m_err_o); else passed++;
        m_req[got] = 1'b0;
        drop[got]  = 1'b1;
        cnt[got]++;
        m_wdata[got*32 +: 32] = {16'hC0DE, 8'(got), 8'(cnt[got])};
        n++;
      end
    end
    total++; if (n != 6) $display("FAIL rr_count: got %0d acks expected 6", n); else passed++;
    m_req = 4'b0;
    tick();
    total++; if (wlog_data.size() != 6) $display("FAIL rr_writes: got %0d writes expected 6", wlog_data.size()); else passed++;
    for (int i = 0; i < 6 && i < wlog_data.size(); i++) begin
      total++;
      if (wlog_addr[i] !== 32'h100 + 32'(exp_order[i]*4) || wlog_data[i] !== {16'hC0DE, 8'(exp_order[i]), 8'(i/3)})
        $display("FAIL rr_wdata%0d: got %h/%h expected %h/%h", i, wlog_addr[i], wlog_data[i],
                 32'h100 + 32'(exp_order[i]*4), {16'hC0DE, 8'(exp_order[i]), 8'(i/3)});
      else passed++;
    end
    total++; if (m_data_o[31:0] !== 32'h4444_4444) $display("FAIL rr_wcapture: got %h expected 44444444", m_data_o[31:0]); else passed++;
  endtask

  task automatic test_unmapped();
    set_master(3, 1'b1, 1'b0, 32'h9000_0000, 32'h0);
    #1;
    total++; if (s_req_o !== 6'b0) $display("FAIL um_idle_sreq: got %b expected 0", s_req_o); else passed++;
    tick();
    total++; if (m_ack_o !== 4'b1000 || m_err_o !== 4'b1000) $display("FAIL um_ack: ack=%b err=%b expected 1000/1000", m_ack_o, m_err_o); else passed++;
    total++; if (m_data_o[127:96] !== 32'h0) $display("FAIL um_data: got %h expected 0", m_data_o[127:96]); else passed++;
    total++; if (m_data_o[31:0] !== 32'h4444_4444) $display("FAIL um_other: got %h expected 44444444", m_data_o[31:0]); else passed++;
    total++; if (s_req_o !== 6'b0) $display("FAIL um_sreq: got %b expected 0", s_req_o); else passed++;
    m_req[3] = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int bad = 0;
    bit ok = 1'b0;
    slv_en[2] = 1'b0;
    set_master(2, 1'b1, 1'b0, 32'h2000_0000, 32'h0);
    tick();
    for (int i = 0; i < 8; i++) begin
      if (s_req_o !== 6'b000100 || m_ack_o !== 4'b0) bad++;
      tick();
    end
    total++; if (bad != 0) $display("FAIL to_busy: %0d bad BUSY cycles expected 0", bad); else passed++;
`ifdef XBUS_RR_TIMEOUT_EN
    total++; if (m_ack_o !== 4'b0100 || m_err_o !== 4'b0100) $display("FAIL to_ack: ack=%b err=%b expected 0100/0100", m_ack_o, m_err_o); else passed++;
    total++; if (m_data_o[95:64] !== 32'h0) $display("FAIL to_data: got %h expected 0", m_data_o[95:64]); else passed++;
    m_req[2] = 1'b0;
    tick();
    slv_data[5] = 32'h5555_0005;
    set_master(1, 1'b1, 1'b0, 32'h5000_0008, 32'h0);
    for (int c = 0; c < 10 && !ok; c++) begin
      tick();
      if (m_ack_o[1]) ok = 1'b1;
    end
    total++; if (!ok || m_err_o !== 4'b0) $display("FAIL to_next: ack_seen=%0d err=%b expected 1/0000", ok, m_err_o); else passed++;
    total++; if (m_data_o[63:32] !== 32'h5555_0005) $display("FAIL to_next_data: got %h expected 55550005", m_data_o[63:32]); else passed++;
    m_req[1] = 1'b0;
    tick();
`else
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (s_req_o !== 6'b000100 || m_ack_o !== 4'b0) bad++;
      tick();
    end
    total++; if (bad != 0) $display("FAIL to_stuck: %0d cycles left BUSY expected 0", bad); else passed++;
`endif
  endtask

  task automatic test_reset_busy();
    if (s_req_o == 6'b0) begin
      set_master(3, 1'b1, 1'b0, 32'h2000_0000, 32'h0);
      tick();
    end
    total++; if (s_req_o[2] !== 1'b1) $display("FAIL rb_pre: got %b expected slave 2 busy", s_req_o); else passed++;
    rst = 1'b1;
    tick();
    total++; if (s_req_o !== 6'b0 || m_ack_o !== 4'b0) $display("FAIL rb_abort: sreq=%b ack=%b expected 0", s_req_o, m_ack_o); else passed++;
    rst = 1'b0;
    slv_en = 6'b111111;
    for (int k = 0; k < 4; k++) set_master(k, 1'b1, 1'b0, 32'h5000_0000 + 32'(k), 32'h0);
    tick();
    total++; if (m_ack_o !== 4'b0 || s_addr_o[191:160] !== 32'h0) $display("FAIL rb_first: ack=%b addr=%h expected 0000/0", m_ack_o, s_addr_o[191:160]); else passed++;
    tick();
    total++; if (m_ack_o !== 4'b0001) $display("FAIL rb_winner: got %b expected 0001", m_ack_o); else passed++;
    m_req = 4'b0;
    tick();
  endtask

  task automatic test_hold();
    #1;
    total++; if (hold_o !== 1'b0) $display("FAIL hd_idle: got %b expected 0", hold_o); else passed++;
    set_master(1, 1'b1, 1'b0, 32'h1000_0000, 32'h0);
    #1;
    total++; if (hold_o !== 1'b0) $display("FAIL hd_m1_req: got %b expected 0", hold_o); else passed++;
    tick();
    m_req[1] = 1'b0;
    #1;
    total++; if (hold_o !== 1'b0) $display("FAIL hd_m1_busy: got %b expected 0", hold_o); else passed++;
    tick();
    total++; if (m_ack_o !== 4'b0010) $display("FAIL hd_drop_ack: got %b expected 0010", m_ack_o); else passed++;
    tick();
    set_master(0, 1'b1, 1'b0, 32'h1000_0004, 32'h0);
    #1;
    total++; if (hold_o !== 1'b1) $display("FAIL hd_m0_req: got %b expected 1", hold_o); else passed++;
    tick();
    tick();
    total++; if (m_ack_o !== 4'b0001 || hold_o !== 1'b1) $display("FAIL hd_m0_ack: ack=%b hold=%b expected 0001/1", m_ack_o, hold_o); else passed++;
    tick();
    total++; if (hold_o !== 1'b1) $display("FAIL hd_m0_after: got %b expected 1", hold_o); else passed++;
    m_req[0] = 1'b0;
    #1;
    total++; if (hold_o !== 1'b0) $display("FAIL hd_m0_drop: got %b expected 0", hold_o); else passed++;
    tick();
    total++; if (s_req_o !== 6'b0 || m_ack_o !== 4'b0) $display("FAIL hd_quiet: sreq=%b ack=%b expected 0", s_req_o, m_ack_o); else passed++;
  endtask

  initial begin
    rst     = 1'b1;
    m_req   = '0;
    m_we    = '0;
    m_addr  = '0;
    m_wdata = '0;
    slv_en  = 6'b111111;
    for (int s = 0; s < 6; s++) slv_data[s] = 32'h0;
    test_reset();
    test_read();
    test_round_robin();
    test_unmapped();
    test_timeout();
    test_reset_busy();
    test_hold();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
